// File: rtl/spi_capture_reader.sv
// SPI master that clocks {pins, timestamp} capture frames in from the capture slave
// and presents them on a valid/ready stream with change detection and timestamp deltas.
module spi_capture_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned PIN_W   = 8,
  parameter int unsigned TS_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              miso,
  output logic              spi_clk,
  output logic              mosi,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIN_W-1:0]  out_pins,
  output logic [TS_W-1:0]   out_ts,
  output logic              out_changed,
  output logic [TS_W-1:0]   out_ts_delta
);

  localparam int unsigned FRAME_BITS = PIN_W + TS_W;
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    spi_clk_q;
  logic                    load;
  logic                    accept;

  logic                    out_valid_q;
  logic [PIN_W-1:0]        out_pins_q;
  logic [TS_W-1:0]         out_ts_q;
  logic                    out_changed_q;
  logic [TS_W-1:0]         out_ts_delta_q;
  logic [PIN_W-1:0]        prev_pins_q;
  logic [TS_W-1:0]         prev_ts_q;
  logic                    first_q;

  assign accept = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOW;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      LOW: begin
        // Sample on the last low cycle so miso has CLK_DIV-1 cycles to settle.
        if (div_q == DIV_LAST) begin
          shift_d = {shift_q[FRAME_BITS-2:0], miso};
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = LOW;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        if (!out_valid_q || out_ready) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      spi_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      // Registered from the next state so spi_clk lines up with HIGH exactly.
      spi_clk_q <= (state_d == HIGH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_pins_q     <= '0;
      out_ts_q       <= '0;
      out_changed_q  <= 1'b0;
      out_ts_delta_q <= '0;
      prev_pins_q    <= '0;
      prev_ts_q      <= '0;
      first_q        <= 1'b1;
    end else if (load) begin
      out_valid_q    <= 1'b1;
      out_pins_q     <= shift_q[FRAME_BITS-1:TS_W];
      out_ts_q       <= shift_q[TS_W-1:0];
      out_changed_q  <= first_q || (shift_q[FRAME_BITS-1:TS_W] != prev_pins_q);
      out_ts_delta_q <= first_q ? '0 : (shift_q[TS_W-1:0] - prev_ts_q);
      prev_pins_q    <= shift_q[FRAME_BITS-1:TS_W];
      prev_ts_q      <= shift_q[TS_W-1:0];
      first_q        <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b0;
    end
  end

  assign spi_clk      = spi_clk_q;
  assign mosi         = 1'b0;
  assign busy         = (state_q != IDLE);
  assign out_valid    = out_valid_q;
  assign out_pins     = out_pins_q;
  assign out_ts       = out_ts_q;
  assign out_changed  = out_changed_q;
  assign out_ts_delta = out_ts_delta_q;

endmodule

// File: tb/tb_spi_capture_reader.sv
// Bench for spi_capture_reader: behavioural capture slave plus a frame-level
// scoreboard that derives pins/ts/changed/delta from the delivered frame sequence.
module tb_spi_capture_reader;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned PIN_W   = 8;
  localparam int unsigned TS_W    = 32;
  localparam int unsigned FB      = PIN_W + TS_W;
  localparam int unsigned LAT     = 2 + 2 * CLK_DIV * FB;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             miso;
  logic             spi_clk;
  logic             mosi;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [PIN_W-1:0] out_pins;
  logic [TS_W-1:0]  out_ts;
  logic             out_changed;
  logic [TS_W-1:0]  out_ts_delta;

  int passed;
  int total;

  spi_capture_reader #(
    .CLK_DIV(CLK_DIV),
    .PIN_W  (PIN_W),
    .TS_W   (TS_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .miso        (miso),
    .spi_clk     (spi_clk),
    .mosi        (mosi),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pins    (out_pins),
    .out_ts      (out_ts),
    .out_changed (out_changed),
    .out_ts_delta(out_ts_delta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture slave: streams queued words MSB first, moving to the next bit after each spi_clk fall.
  logic [FB-1:0] slave_q[$];
  logic [FB-1:0] cur;
  int            idx;
  bit            loaded;
  logic          prev_sclk;

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      idx       = 0;
      loaded    = 1'b0;
      prev_sclk = 1'b0;
    end else begin
      if (prev_sclk && !spi_clk) begin
        if (idx == FB - 1) begin
          idx    = 0;
          loaded = 1'b0;
        end else begin
          idx++;
        end
      end
      prev_sclk = spi_clk;
      if (!loaded && slave_q.size() > 0) begin
        cur    = slave_q.pop_front();
        loaded = 1'b1;
      end
    end
    miso = loaded ? cur[FB-1-idx] : 1'b0;
  end

  // Reference: expected delivery order plus delivered-frame history.
  logic [FB-1:0]    exp_q[$];
  logic [PIN_W-1:0] m_prev_pins;
  logic [TS_W-1:0]  m_prev_ts;
  bit               m_first;

  task automatic push_frame(input logic [PIN_W-1:0] p, input logic [TS_W-1:0] t);
    slave_q.push_back({p, t});
    exp_q.push_back({p, t});
  endtask

  task automatic model_reset();
    m_first     = 1'b1;
    m_prev_pins = '0;
    m_prev_ts   = '0;
  endtask

  task automatic model_next(output logic [PIN_W-1:0] p, output logic [TS_W-1:0] t,
                            output logic c, output logic [TS_W-1:0] d);
    logic [FB-1:0] w;
    w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    p = w[FB-1:TS_W];
    t = w[TS_W-1:0];
    c = m_first || (p != m_prev_pins);
    d = m_first ? '0 : t - m_prev_ts;
    m_first     = 1'b0;
    m_prev_pins = p;
    m_prev_ts   = t;
  endtask

  task automatic pulse_enable();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if ({spi_clk, busy, out_valid, mosi} !== 4'b0000)
        $display("FAIL reset_idle cycle %0d: {spi_clk,busy,out_valid,mosi}=%b expected 0000", i, {spi_clk, busy, out_valid, mosi});
      else passed++;
    end
    total++;
    if (out_pins !== '0) $display("FAIL reset_pins got %h expected 0", out_pins); else passed++;
    total++;
    if (out_ts !== '0) $display("FAIL reset_ts got %h expected 0", out_ts); else passed++;
    total++;
    if (out_ts_delta !== '0) $display("FAIL reset_delta got %h expected 0", out_ts_delta); else passed++;
    total++;
    if (out_changed !== 1'b0) $display("FAIL reset_changed got %b expected 0", out_changed); else passed++;
  endtask

  task automatic test_first_frame();
    logic [PIN_W-1:0] ep;
    logic [TS_W-1:0]  et, ed;
    logic             ec;
    int               c;
    out_ready = 1'b1;
    push_frame(8'hD2, 32'h0000_0005);
    pulse_enable();
    total++;
    if (busy !== 1'b1) $display("FAIL first_busy got %b expected 1", busy); else passed++;
    wait_valid(LAT + 50, c);
    total++;
    if (1 + c !== LAT) $display("FAIL first_latency got %0d cycles expected %0d", 1 + c, LAT); else passed++;
    model_next(ep, et, ec, ed);
    total++;
    if (out_pins !== ep) $display("FAIL first_pins got %h expected %h", out_pins, ep); else passed++;
    total++;
    if (out_ts !== et) $display("FAIL first_ts got %h expected %h", out_ts, et); else passed++;
    total++;
    if (out_changed !== ec) $display("FAIL first_changed got %b expected %b", out_changed, ec); else passed++;
    total++;
    if (out_ts_delta !== ed) $display("FAIL first_delta got %h expected %h", out_ts_delta, ed); else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL first_accept out_valid got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_deltas();
    logic [PIN_W-1:0] pins[2];
    logic [TS_W-1:0]  tss[2];
    logic [PIN_W-1:0] ep;
    logic [TS_W-1:0]  et, ed;
    logic             ec;
    int               c;
    pins[0] = 8'h2D; tss[0] = 32'h12;
    pins[1] = 8'h2D; tss[1] = 32'h20;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_frame(pins[i], tss[i]);
      pulse_enable();
      wait_valid(LAT + 50, c);
      total++;
      if (out_valid !== 1'b1) $display("FAIL deltas_timeout frame %0d got out_valid %b expected 1", i, out_valid); else passed++;
      model_next(ep, et, ec, ed);
      total++;
      if ({out_pins, out_ts} !== {ep, et}) $display("FAIL deltas_data frame %0d got %h/%h expected %h/%h", i, out_pins, out_ts, ep, et); else passed++;
      total++;
      if (out_changed !== ec) $display("FAIL deltas_changed frame %0d got %b expected %b", i, out_changed, ec); else passed++;
      total++;
      if (out_ts_delta !== ed) $display("FAIL deltas_delta frame %0d got %h expected %h", i, out_ts_delta, ed); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [PIN_W-1:0] ep;
    logic [TS_W-1:0]  et, ed;
    logic             ec;
    int               cyc;
    out_ready = 1'b0;
    push_frame(8'($urandom), $urandom);
    push_frame(8'($urandom), $urandom);
    @(negedge clk);
    enable = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < int'(LAT) + 50) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (out_valid !== 1'b1) $display("FAIL stall_first_timeout got out_valid %b expected 1", out_valid); else passed++;
    model_next(ep, et, ec, ed);
    total++;
    if ({out_pins, out_ts, out_changed, out_ts_delta} !== {ep, et, ec, ed})
      $display("FAIL stall_first_data got %h/%h/%b/%h expected %h/%h/%b/%h", out_pins, out_ts, out_changed, out_ts_delta, ep, et, ec, ed);
    else passed++;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      total++;
      if ({out_valid, out_pins, out_ts} !== {1'b1, ep, et})
        $display("FAIL stall_hold cycle %0d got %b/%h/%h expected 1/%h/%h", cyc, out_valid, out_pins, out_ts, ep, et);
      else passed++;
    end
    total++;
    if ({spi_clk, busy} !== 2'b01) $display("FAIL stall_done {spi_clk,busy} got %b expected 01", {spi_clk, busy}); else passed++;
    enable = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    model_next(ep, et, ec, ed);
    total++;
    if (out_valid !== 1'b1) $display("FAIL stall_reload out_valid got %b expected 1", out_valid); else passed++;
    total++;
    if ({out_pins, out_ts, out_changed, out_ts_delta} !== {ep, et, ec, ed})
      $display("FAIL stall_second_data got %h/%h/%b/%h expected %h/%h/%b/%h", out_pins, out_ts, out_changed, out_ts_delta, ep, et, ec, ed);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL stall_drain out_valid got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_wrap();
    logic [PIN_W-1:0] ep;
    logic [TS_W-1:0]  et, ed;
    logic             ec;
    int               c;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_frame(8'($urandom), (i == 0) ? 32'hFFFF_FFF0 : 32'h0000_0010);
      pulse_enable();
      wait_valid(LAT + 50, c);
      total++;
      if (out_valid !== 1'b1) $display("FAIL wrap_timeout frame %0d got out_valid %b expected 1", i, out_valid); else passed++;
      model_next(ep, et, ec, ed);
      total++;
      if ({out_pins, out_ts, out_changed} !== {ep, et, ec})
        $display("FAIL wrap_data frame %0d got %h/%h/%b expected %h/%h/%b", i, out_pins, out_ts, out_changed, ep, et, ec);
      else passed++;
      if (i == 1) begin
        total++;
        if (out_ts_delta !== 32'h20) $display("FAIL wrap_delta got %h expected 00000020", out_ts_delta); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [PIN_W-1:0] ep;
    logic [TS_W-1:0]  et, ed;
    logic             ec;
    logic             prev;
    int               c, falls;
    out_ready = 1'b0;
    push_frame(8'($urandom), $urandom);
    pulse_enable();
    wait_valid(LAT + 50, c);
    model_next(ep, et, ec, ed);
    total++;
    if ({out_valid, out_pins, out_ts} !== {1'b1, ep, et})
      $display("FAIL rstmid_held got %b/%h/%h expected 1/%h/%h", out_valid, out_pins, out_ts, ep, et);
    else passed++;
    push_frame(8'($urandom), $urandom);
    pulse_enable();
    falls = 0;
    prev = spi_clk;
    c = 0;
    while (!(falls == 17 && spi_clk) && c < int'(LAT) + 50) begin
      @(negedge clk);
      c++;
      if (prev && !spi_clk) falls++;
      prev = spi_clk;
    end
    total++;
    if ({falls, spi_clk} !== {32'd17, 1'b1}) $display("FAIL rstmid_position got falls %0d spi_clk %b expected 17 1", falls, spi_clk); else passed++;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    total++;
    if ({spi_clk, out_valid, busy} !== 3'b000) $display("FAIL rstmid_clear {spi_clk,out_valid,busy} got %b expected 000", {spi_clk, out_valid, busy}); else passed++;
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    push_frame(8'($urandom), $urandom);
    pulse_enable();
    wait_valid(LAT + 50, c);
    total++;
    if (1 + c !== LAT) $display("FAIL rstmid_latency got %0d expected %0d", 1 + c, LAT); else passed++;
    model_next(ep, et, ec, ed);
    total++;
    if ({out_pins, out_ts, out_changed, out_ts_delta} !== {ep, et, ec, ed})
      $display("FAIL rstmid_next got %h/%h/%b/%h expected %h/%h/%b/%h", out_pins, out_ts, out_changed, out_ts_delta, ep, et, ec, ed);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [PIN_W-1:0] ep, p;
    logic [TS_W-1:0]  et, ed;
    logic             ec;
    int               c;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = ($urandom_range(0, 2) == 0) ? m_prev_pins : 8'($urandom);
      push_frame(p, $urandom);
      pulse_enable();
      wait_valid(LAT + 50, c);
      total++;
      if (out_valid !== 1'b1) $display("FAIL random_timeout frame %0d got out_valid %b expected 1", i, out_valid); else passed++;
      model_next(ep, et, ec, ed);
      total++;
      if ({out_pins, out_ts, out_changed, out_ts_delta} !== {ep, et, ec, ed})
        $display("FAIL random_data frame %0d got %h/%h/%b/%h expected %h/%h/%b/%h", i, out_pins, out_ts, out_changed, out_ts_delta, ep, et, ec, ed);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_first_frame();
    test_deltas();
    test_back_to_back_stall();
    test_wrap();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
